// File: rtl/exec_cc_unit.sv
// Execute-stage sequencer: operand latch, add/sub/and/xor, CC register and branch condition.
// Define EXEC_CC_STALL_CNT_EN to add the stall_cnt output-backpressure counter.
module exec_cc_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic             set_cc,
    input  logic [3:0]       cond_fn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic             err,
    output logic [2:0]       cc
`ifdef EXEC_CC_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [3:0]       op_ifun;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_set;
    logic [3:0]       op_cond;
    logic [2:0]       cc_snap;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             legal;
    logic             zf, sf, of;
    logic             cnd_nxt;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Ripple-carry adder; subtraction inverts A and injects carry-in 1.
    always_comb begin
        logic m;
        logic c;
        m   = (op_ifun == 4'd1);
        c   = m;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic bi;
            bi     = op_a[i] ^ m;
            sum[i] = op_b[i] ^ bi ^ c;
            c      = (op_b[i] & bi) | (c & (op_b[i] ^ bi));
        end
    end

    always_comb begin
        res   = '0;
        legal = 1'b1;
        of    = 1'b0;
        unique case (op_ifun)
            4'd0: begin
                res = sum;
                of  = (op_a[WIDTH-1] == op_b[WIDTH-1])
                   && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1: begin
                res = sum;
                of  = (op_a[WIDTH-1] != op_b[WIDTH-1])
                   && (sum[WIDTH-1] != op_b[WIDTH-1]);
            end
            4'd2:    res = op_a & op_b;
            4'd3:    res = op_a ^ op_b;
            default: legal = 1'b0;
        endcase
        zf = (res == '0);
        sf = res[WIDTH-1];
    end

    // Condition uses the CC captured at acceptance, not this op's flags.
    always_comb begin
        logic z, s, o;
        {z, s, o} = cc_snap;
        cnd_nxt = 1'b0;
        unique case (op_cond)
            4'd0:    cnd_nxt = 1'b1;
            4'd1:    cnd_nxt = (s ^ o) | z;
            4'd2:    cnd_nxt = s ^ o;
            4'd3:    cnd_nxt = z;
            4'd4:    cnd_nxt = ~z;
            4'd5:    cnd_nxt = ~(s ^ o);
            4'd6:    cnd_nxt = ~(s ^ o) & ~z;
            default: cnd_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_ifun <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_set  <= 1'b0;
            op_cond <= '0;
            cc_snap <= 3'b100;
            valE    <= '0;
            cnd     <= 1'b0;
            err     <= 1'b0;
            cc      <= 3'b100;
        end else begin
            if (accept) begin
                op_ifun <= ifun;
                op_a    <= valA;
                op_b    <= valB;
                op_set  <= set_cc;
                op_cond <= cond_fn;
                cc_snap <= cc;
            end
            if (state == CALC) begin
                valE <= res;
                err  <= !legal;
                cnd  <= cnd_nxt;
                if (op_set && legal) cc <= {zf, sf, of};
            end
        end
    end

`ifdef EXEC_CC_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_exec_cc_unit.sv
// Self-checking bench for exec_cc_unit: directed scenarios plus randomized ops
// compared against a signed-arithmetic reference model.
module tb_exec_cc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ifun;
    logic [63:0] valA, valB;
    logic        set_cc;
    logic [3:0]  cond_fn;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd, err;
    logic [2:0]  cc;
`ifdef EXEC_CC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] m_cc;

    always #5 clk = ~clk;

    exec_cc_unit #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ifun(ifun), .valA(valA), .valB(valB),
        .set_cc(set_cc), .cond_fn(cond_fn),
        .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .cnd(cnd), .err(err), .cc(cc)
`ifdef EXEC_CC_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Reference: signed 65-bit arithmetic; overflow when the true sum leaves int64 range.
    task automatic model(input logic [3:0] f, input logic [63:0] a, b,
                         input logic s, input logic [3:0] c, input logic [2:0] cc_in,
                         output logic [63:0] ve, output logic er, output logic cn,
                         output logic [2:0] cc_out);
        longint sa, sb;
        logic signed [64:0] wide;
        logic ovf;
        logic z, sg, o;
        sa = a; sb = b;
        ovf = 1'b0; er = 1'b0; ve = 64'd0;
        case (f)
            4'd0: begin wide = 65'(sb) + 65'(sa); ve = wide[63:0];
                ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000); end
            4'd1: begin wide = 65'(sb) - 65'(sa); ve = wide[63:0];
                ovf = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000); end
            4'd2: ve = a & b;
            4'd3: ve = a ^ b;
            default: er = 1'b1;
        endcase
        {z, sg, o} = cc_in;
        case (c)
            4'd0: cn = 1'b1;
            4'd1: cn = (sg != o) || z;
            4'd2: cn = (sg != o);
            4'd3: cn = z;
            4'd4: cn = !z;
            4'd5: cn = (sg == o);
            4'd6: cn = (sg == o) && !z;
            default: cn = 1'b0;
        endcase
        if (s && !er) cc_out = {ve == 64'd0, ve[63], ovf};
        else          cc_out = cc_in;
    endtask

    task automatic run_op(input logic [3:0] f, input logic [63:0] a, b,
                          input logic s, input logic [3:0] c,
                          output logic ov, output logic [63:0] ve,
                          output logic cn, er, output logic [2:0] ccv,
                          output logic tmo);
        @(negedge clk);
        in_valid = 1'b1; ifun = f; valA = a; valB = b;
        set_cc = s; cond_fn = c; out_ready = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) begin tmo = 1'b0; break; end
            @(negedge clk);
        end
        if (tmo) begin
            in_valid = 1'b0;
            ov = 1'bx; ve = 'x; cn = 1'bx; er = 1'bx; ccv = 'x;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        ov = out_valid; ve = valE; cn = cnd; er = err; ccv = cc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b need 0/0", in_ready, out_valid);
        end
        n_tests++;
        if (valE !== 64'd0 || cc !== 3'b100 || err !== 1'b0 || cnd !== 1'b0) begin
            n_fail++; $display("FAIL reset_vals: valE=%h cc=%b err=%b cnd=%b need 0/100/0/0", valE, cc, err, cnd);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b need 1", in_ready);
        end
`ifdef EXEC_CC_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall: stall_cnt=%0d need 0", stall_cnt);
        end
`endif
        m_cc = 3'b100;
    endtask

    task automatic check_op(input string nm, input logic [3:0] f, input logic [63:0] a, b,
                            input logic s, input logic [3:0] c);
        logic ov, cn, er, tmo, e_er, e_cn;
        logic [63:0] ve, e_ve;
        logic [2:0] ccv, e_cc;
        model(f, a, b, s, c, m_cc, e_ve, e_er, e_cn, e_cc);
        run_op(f, a, b, s, c, ov, ve, cn, er, ccv, tmo);
        n_tests++;
        if (tmo || ov !== 1'b1 || ve !== e_ve || er !== e_er || cn !== e_cn || ccv !== e_cc) begin
            n_fail++;
            $display("FAIL %s: tmo=%b ov=%b valE=%h err=%b cnd=%b cc=%b need ov=1 valE=%h err=%b cnd=%b cc=%b",
                     nm, tmo, ov, ve, er, cn, ccv, e_ve, e_er, e_cn, e_cc);
        end
        m_cc = e_cc;
    endtask

    task automatic test_add_overflow;
        check_op("add_ovf", 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        n_tests++;
        if (cc !== 3'b011 || valE !== 64'h8000_0000_0000_0000) begin
            n_fail++; $display("FAIL add_ovf_const: cc=%b valE=%h need 011/8000000000000000", cc, valE);
        end
    endtask

    task automatic test_sub_cond;
        check_op("sub_zero", 4'd1, 64'd5, 64'd5, 1'b1, 4'd0);
        n_tests++;
        if (cc !== 3'b100 || valE !== 64'd0) begin
            n_fail++; $display("FAIL sub_zero_const: cc=%b valE=%h need 100/0", cc, valE);
        end
        check_op("cond_e", 4'd2, 64'd3, 64'd1, 1'b0, 4'd3);
        n_tests++;
        if (cnd !== 1'b1) begin
            n_fail++; $display("FAIL cond_e_const: cnd=%b need 1", cnd);
        end
        check_op("cond_ne", 4'd2, 64'd3, 64'd1, 1'b0, 4'd4);
        n_tests++;
        if (cnd !== 1'b0) begin
            n_fail++; $display("FAIL cond_ne_const: cnd=%b need 0", cnd);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] held;
        logic bad;
        @(negedge clk);
        in_valid = 1'b1; ifun = 4'd0; valA = 64'd10; valB = 64'd20;
        set_cc = 1'b0; cond_fn = 4'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || valE !== 64'd30) begin
            n_fail++; $display("FAIL bp_first: out_valid=%b valE=%h need 1/1e", out_valid, valE);
        end
        held = valE;
        in_valid = 1'b1; ifun = 4'd3; valA = 64'hAAAA; valB = 64'h5555;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valE !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL bp_hold: valE=%h in_ready=%b out_valid=%b need %h/0/1", valE, in_ready, out_valid, held);
        end
`ifdef EXEC_CC_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== 32'd4) begin
            n_fail++; $display("FAIL bp_stall: stall_cnt=%0d need 4", stall_cnt);
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || valE !== 64'd30) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b valE=%h need 0/1/1e", out_valid, in_ready, valE);
        end
    endtask

    task automatic test_illegal;
        check_op("cc_010", 4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd0);
        check_op("illegal", 4'd7, 64'h1234, 64'h5678, 1'b1, 4'd2);
        n_tests++;
        if (err !== 1'b1 || valE !== 64'd0 || cc !== 3'b010) begin
            n_fail++; $display("FAIL illegal_const: err=%b valE=%h cc=%b need 1/0/010", err, valE, cc);
        end
    endtask

    task automatic test_logic;
        check_op("xor_zero", 4'd3, '1, '1, 1'b1, 4'd0);
        n_tests++;
        if (cc !== 3'b100) begin
            n_fail++; $display("FAIL xor_const: cc=%b need 100", cc);
        end
        check_op("and_neg", 4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd0);
        n_tests++;
        if (cc !== 3'b010) begin
            n_fail++; $display("FAIL and_const: cc=%b need 010", cc);
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        in_valid = 1'b1; ifun = 4'd1; valA = 64'd7; valB = 64'd7;
        set_cc = 1'b1; cond_fn = 4'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || cc !== 3'b100 || valE !== 64'd0) begin
            n_fail++; $display("FAIL rst_mid: out_valid=%b cc=%b valE=%h need 0/100/0", out_valid, cc, valE);
        end
        @(negedge clk);
        rst = 1'b0;
        m_cc = 3'b100;
    endtask

    task automatic test_random;
        logic [63:0] a, b;
        logic [3:0] f;
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                2: b = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
                default: b = {$urandom, $urandom};
            endcase
            f = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            check_op($sformatf("rand%0d", i), f, a, b, 1'($urandom), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ifun = '0; valA = '0; valB = '0;
        set_cc = 1'b0; cond_fn = '0; out_ready = 1'b0;
        m_cc = 3'b100;
        test_reset;
        test_backpressure;
        test_add_overflow;
        test_sub_cond;
        test_illegal;
        test_logic;
        test_reset_midflight;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
